// File: rtl/mcdf_ctrl_regs_pkg.sv
// Shared definitions for the MCDF control-register path: command encodings,
// register map, config field layout and helpers to pack/unpack config fields.
package mcdf_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_RD   = 2'b01,
        CMD_WR   = 2'b10,
        CMD_ILL  = 2'b11
    } cmd_e;

    localparam logic [7:0] SLV0_RW = 8'h00;
    localparam logic [7:0] SLV1_RW = 8'h04;
    localparam logic [7:0] SLV2_RW = 8'h08;
    localparam logic [7:0] SLV0_R  = 8'h10;
    localparam logic [7:0] SLV1_R  = 8'h14;
    localparam logic [7:0] SLV2_R  = 8'h18;

    localparam int EN_LSB   = 0;
    localparam int EN_W     = 1;
    localparam int PRIO_LSB = 1;
    localparam int PRIO_W   = 2;
    localparam int LEN_LSB  = 3;
    localparam int LEN_W    = 3;
    localparam int CFG_W    = EN_W + PRIO_W + LEN_W;

    localparam logic [31:0] RW_RST = 32'h0000_0007;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [PRIO_W-1:0] prio;
        logic              en;
    } slv_cfg_t;

    function automatic logic [7:0] rw_addr(input int ch);
        case (ch)
            0:       return SLV0_RW;
            1:       return SLV1_RW;
            default: return SLV2_RW;
        endcase
    endfunction

    function automatic logic [7:0] ro_addr(input int ch);
        case (ch)
            0:       return SLV0_R;
            1:       return SLV1_R;
            default: return SLV2_R;
        endcase
    endfunction

    function automatic slv_cfg_t cfg_from_bits(input logic [CFG_W-1:0] b);
        slv_cfg_t c;
        c.en   = b[EN_LSB];
        c.prio = b[PRIO_LSB +: PRIO_W];
        c.len  = b[LEN_LSB +: LEN_W];
        return c;
    endfunction

    function automatic logic [CFG_W-1:0] cfg_to_bits(input slv_cfg_t c);
        logic [CFG_W-1:0] b;
        b                      = '0;
        b[EN_LSB]              = c.en;
        b[PRIO_LSB +: PRIO_W]  = c.prio;
        b[LEN_LSB +: LEN_W]    = c.len;
        return b;
    endfunction

endpackage

// File: rtl/mcdf_ctrl_regs_slice.sv
// One channel's RW configuration register: stores the config field bits on a
// write strobe and presents them both as decoded fields and as a read word.
module ctrl_reg_slice
    import mcdf_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter logic [31:0] RST_VAL = mcdf_pkg::RW_RST
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_wr_en,
    input  logic [CFG_W-1:0]     i_wr_cfg,
    output slv_cfg_t             o_cfg,
    output logic [DATA_W-1:0]    o_rd_val
);

    slv_cfg_t r_cfg;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_cfg <= cfg_from_bits(RST_VAL[CFG_W-1:0]);
        end else if (i_wr_en) begin
            r_cfg <= cfg_from_bits(i_wr_cfg);
        end
    end

    // Reserved bits above the config fields always read back as zero.
    assign o_cfg    = r_cfg;
    assign o_rd_val = {{(DATA_W-CFG_W){1'b0}}, cfg_to_bits(r_cfg)};

endmodule

// File: rtl/mcdf_ctrl_regs.sv
// MCDF control/status register block: per-channel RW config (enable, priority,
// packet length) and RO FIFO-margin status behind a simple cmd/addr/data port.
module mcdf_ctrl_regs
    import mcdf_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter int          DATA_W  = 32,
    parameter int          NUM_CH  = 3,
    parameter int          AVAIL_W = 8,
    parameter logic [31:0] RW_RST  = mcdf_pkg::RW_RST
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [1:0]                i_cmd,
    input  logic [ADDR_W-1:0]         i_cmd_addr,
    input  logic [DATA_W-1:0]         i_cmd_data_w,
    output logic [DATA_W-1:0]         o_cmd_data_r,
    output logic                      o_cmd_err,
    input  logic [NUM_CH*AVAIL_W-1:0] i_slv_avail,
    output logic [NUM_CH-1:0]         o_slv_en,
    output logic [NUM_CH*2-1:0]       o_slv_prio,
    output logic [NUM_CH*3-1:0]       o_slv_len
);

    cmd_e                w_cmd;
    logic [NUM_CH-1:0]   w_rw_sel;
    logic [NUM_CH-1:0]   w_ro_sel;
    logic                w_mapped;
    logic [NUM_CH-1:0]   w_wr_en;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_err;
    slv_cfg_t            w_cfg     [NUM_CH];
    logic [DATA_W-1:0]   w_slice_rd[NUM_CH];
    logic                w_unused;

    logic [DATA_W-1:0]   r_cmd_data_r;
    logic                r_cmd_err;

    assign w_cmd = cmd_e'(i_cmd);

    // Full-width compare so no address aliases onto a register.
    always_comb begin
        w_rw_sel = '0;
        w_ro_sel = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_rw_sel[ch] = (i_cmd_addr == ADDR_W'(rw_addr(ch)));
            w_ro_sel[ch] = (i_cmd_addr == ADDR_W'(ro_addr(ch)));
        end
    end

    assign w_mapped = (|w_rw_sel) | (|w_ro_sel);
    assign w_wr_en  = (w_cmd == CMD_WR) ? w_rw_sel : '0;

    always_comb begin
        w_rd_data = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_rw_sel[ch]) begin
                w_rd_data = w_slice_rd[ch];
            end
            if (w_ro_sel[ch]) begin
                w_rd_data = DATA_W'(i_slv_avail[ch*AVAIL_W +: AVAIL_W]);
            end
        end
    end

    // Writes are only legal to RW slots; reads are legal to any mapped slot.
    always_comb begin
        w_err = 1'b0;
        case (w_cmd)
            CMD_IDLE: w_err = 1'b0;
            CMD_RD:   w_err = ~w_mapped;
            CMD_WR:   w_err = ~(|w_rw_sel);
            CMD_ILL:  w_err = 1'b1;
            default:  w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_cmd_data_r <= '0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_cmd_err <= w_err;
            if (w_cmd == CMD_RD) begin
                r_cmd_data_r <= w_rd_data;
            end
        end
    end

    assign o_cmd_data_r = r_cmd_data_r;
    assign o_cmd_err    = r_cmd_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ctrl_reg_slice #(
            .DATA_W  (DATA_W),
            .RST_VAL (RW_RST)
        ) u_slice (
            .clk      (clk),
            .rstn     (rstn),
            .i_wr_en  (w_wr_en[gi]),
            .i_wr_cfg (i_cmd_data_w[CFG_W-1:0]),
            .o_cfg    (w_cfg[gi]),
            .o_rd_val (w_slice_rd[gi])
        );

        assign o_slv_en[gi]         = w_cfg[gi].en;
        assign o_slv_prio[gi*2 +: 2] = w_cfg[gi].prio;
        assign o_slv_len[gi*3 +: 3]  = w_cfg[gi].len;
    end

    // Reserved write-data bits are intentionally dropped.
    assign w_unused = &{1'b0, i_cmd_data_w[DATA_W-1:CFG_W]};

endmodule

// File: tb/tb_mcdf_ctrl_regs.sv
// Self-checking bench for mcdf_ctrl_regs: directed vector table, hand-written
// reset corner case, then randomized commands against a behavioural model.
module tb_mcdf_ctrl_regs;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] WR   = 2'b10;
    localparam logic [1:0] ILL  = 2'b11;

    typedef struct {
        logic [1:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [23:0] avail;
        logic [31:0] expRd;
        logic        expErr;
        logic [2:0]  expEn;
        logic [5:0]  expPrio;
        logic [8:0]  expLen;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  cmd;
    logic [7:0]  cmdAddr;
    logic [31:0] cmdDataW;
    logic [31:0] cmdDataR;
    logic        cmdErr;
    logic [23:0] slvAvail;
    logic [2:0]  slvEn;
    logic [5:0]  slvPrio;
    logic [8:0]  slvLen;

    int nChecks = 0;
    int nPass   = 0;

    vec_t vecs[$];

    logic [5:0]  mCfg[3];
    logic [31:0] mRd;
    logic        mErr;

    always #5 clk = ~clk;

    mcdf_ctrl_regs dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_cmd        (cmd),
        .i_cmd_addr   (cmdAddr),
        .i_cmd_data_w (cmdDataW),
        .o_cmd_data_r (cmdDataR),
        .o_cmd_err    (cmdErr),
        .i_slv_avail  (slvAvail),
        .o_slv_en     (slvEn),
        .o_slv_prio   (slvPrio),
        .o_slv_len    (slvLen)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the command's effect visible.
    task automatic applyStimulus(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d, input logic [23:0] av);
        cmd      = c;
        cmdAddr  = a;
        cmdDataW = d;
        slvAvail = av;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAll(input string tag, input logic [31:0] rd, input logic err,
                            input logic [2:0] en, input logic [5:0] prio, input logic [8:0] len);
        checkOutput({tag, "_rd"},   cmdDataR,       rd);
        checkOutput({tag, "_err"},  32'(cmdErr),    32'(err));
        checkOutput({tag, "_en"},   32'(slvEn),     32'(en));
        checkOutput({tag, "_prio"}, 32'(slvPrio),   32'(prio));
        checkOutput({tag, "_len"},  32'(slvLen),    32'(len));
    endtask

    // Reference model: register map semantics computed directly from the address table.
    task automatic modelStep(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d, input logic [23:0] av);
        int rwIdx;
        int roIdx;
        rwIdx = -1;
        roIdx = -1;
        for (int i = 0; i < 3; i++) begin
            if (a == 8'(4 * i))        rwIdx = i;
            if (a == 8'(16 + 4 * i))   roIdx = i;
        end
        mErr = 1'b0;
        case (c)
            RD: begin
                if (rwIdx >= 0)      mRd = {26'd0, mCfg[rwIdx]};
                else if (roIdx >= 0) mRd = (32'(av) >> (8 * roIdx)) & 32'hFF;
                else begin
                    mRd  = 32'd0;
                    mErr = 1'b1;
                end
            end
            WR: begin
                if (rwIdx >= 0) mCfg[rwIdx] = d[5:0];
                else            mErr = 1'b1;
            end
            ILL:     mErr = 1'b1;
            default: mErr = 1'b0;
        endcase
    endtask

    task automatic modelOutputs(output logic [2:0] en, output logic [5:0] prio, output logic [8:0] len);
        for (int i = 0; i < 3; i++) begin
            en[i]           = mCfg[i][0];
            prio[2*i +: 2]  = mCfg[i][2:1];
            len[3*i +: 3]   = mCfg[i][5:3];
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [2:0]  eEn;
        logic [5:0]  ePrio;
        logic [8:0]  eLen;
        logic [1:0]  rc;
        logic [7:0]  ra;
        logic [31:0] rdat;
        logic [23:0] rav;
        int          sel;

        rstn     = 1'b1;
        cmd      = IDLE;
        cmdAddr  = 8'h00;
        cmdDataW = 32'h0;
        slvAvail = 24'h0;

        vecs.push_back('{RD,   8'h00, 32'h0,         24'h000000, 32'h07, 1'b0, 3'b111, 6'h3F, 9'h000});
        vecs.push_back('{RD,   8'h04, 32'h0,         24'h000000, 32'h07, 1'b0, 3'b111, 6'h3F, 9'h000});
        vecs.push_back('{RD,   8'h08, 32'h0,         24'h000000, 32'h07, 1'b0, 3'b111, 6'h3F, 9'h000});
        vecs.push_back('{WR,   8'h04, 32'hFFFF_FFC9, 24'h000000, 32'h07, 1'b0, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{RD,   8'h04, 32'h0,         24'h000000, 32'h09, 1'b0, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{RD,   8'h10, 32'h0,         24'h051120, 32'h20, 1'b0, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{RD,   8'h14, 32'h0,         24'h051120, 32'h11, 1'b0, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{RD,   8'h18, 32'h0,         24'h051120, 32'h05, 1'b0, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{WR,   8'h10, 32'h0,         24'h051120, 32'h05, 1'b1, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{RD,   8'h10, 32'h0,         24'h051120, 32'h20, 1'b0, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{RD,   8'h0C, 32'h0,         24'h051120, 32'h00, 1'b1, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{RD,   8'h01, 32'h0,         24'h051120, 32'h00, 1'b1, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{ILL,  8'h00, 32'hFFFF_FFFF, 24'h051120, 32'h00, 1'b1, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{IDLE, 8'h00, 32'h0,         24'h051120, 32'h00, 1'b0, 3'b111, 6'h33, 9'h008});
        vecs.push_back('{WR,   8'h08, 32'h0000_003E, 24'h051120, 32'h00, 1'b0, 3'b011, 6'h33, 9'h1C8});
        vecs.push_back('{RD,   8'h08, 32'h0,         24'h051120, 32'h3E, 1'b0, 3'b011, 6'h33, 9'h1C8});

        repeat (3) @(negedge clk);
        checkAll("reset", 32'h0, 1'b0, 3'b111, 6'h3F, 9'h000);
        rstn = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].avail);
            checkAll($sformatf("vec%0d", i), vecs[i].expRd, vecs[i].expErr,
                     vecs[i].expEn, vecs[i].expPrio, vecs[i].expLen);
        end

        // Reset asserted while a write is being presented: state clears at once and the write is lost.
        applyStimulus(WR, 8'h00, 32'h0, 24'h051120);
        checkOutput("wr00_en", 32'(slvEn), 32'(3'b010));
        cmd      = WR;
        cmdAddr  = 8'h08;
        cmdDataW = 32'h0;
        #2 rstn  = 1'b1;
        #1;
        checkAll("asyncRst", 32'h0, 1'b0, 3'b111, 6'h3F, 9'h000);
        @(posedge clk);
        @(negedge clk);
        checkAll("rstHold", 32'h0, 1'b0, 3'b111, 6'h3F, 9'h000);
        rstn = 1'b0;
        applyStimulus(IDLE, 8'h00, 32'h0, 24'h0);
        applyStimulus(RD, 8'h00, 32'h0, 24'h0);
        checkOutput("postRst_rd00", cmdDataR, 32'h7);
        applyStimulus(RD, 8'h04, 32'h0, 24'h0);
        checkOutput("postRst_rd04", cmdDataR, 32'h7);
        applyStimulus(RD, 8'h08, 32'h0, 24'h0);
        checkOutput("postRst_rd08", cmdDataR, 32'h7);
        checkOutput("postRst_en", 32'(slvEn), 32'(3'b111));

        // Fresh reset so the model starts from a known state.
        rstn = 1'b1;
        cmd  = IDLE;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) mCfg[i] = 6'h07;
        mRd  = 32'h0;
        mErr = 1'b0;

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3)      rc = RD;
            else if (sel <= 6) rc = WR;
            else if (sel <= 8) rc = IDLE;
            else               rc = ILL;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       ra = 8'h00;
                1:       ra = 8'h04;
                2:       ra = 8'h08;
                3:       ra = 8'h10;
                4:       ra = 8'h14;
                5:       ra = 8'h18;
                default: ra = 8'($urandom);
            endcase
            rdat = $urandom;
            rav  = 24'($urandom);
            modelStep(rc, ra, rdat, rav);
            applyStimulus(rc, ra, rdat, rav);
            modelOutputs(eEn, ePrio, eLen);
            checkAll($sformatf("rnd%0d", n), mRd, mErr, eEn, ePrio, eLen);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mcdf_ctrl_regs.md
Name: mcdf_ctrl_regs

Overview:
Control/status register block of the MCDF, directly downstream of the control-register stimulus stage; consumes cmd/cmd_addr/cmd_data_w and returns cmd_data_r.
Holds per-channel configuration (enable, priority, packet length) for the three slave channels and exposes per-channel FIFO margin as read-only status.
Configuration outputs drive the arbiter and formatter.
Single clock domain.

Parameters:
ADDR_W, 8, width of cmd_addr
DATA_W, 32, width of cmd_data_w / cmd_data_r
NUM_CH, 3, number of slave channels (fixed at 3 for address map; other values unsupported)
AVAIL_W, 8, width of each FIFO-margin status field
RW_RST, 32'h0000_0007, reset value of each RW config register

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-high
cmd  in  2  command: 00 IDLE, 01 RD, 10 WR, 11 illegal
cmd_addr  in  ADDR_W  register byte address
cmd_data_w  in  DATA_W  write data
cmd_data_r  out  DATA_W  read data, registered
cmd_err  out  1  one-cycle pulse on illegal cmd or unmapped address
slv_avail  in  NUM_CH*AVAIL_W  FIFO free-entry count per channel, ch0 in LSBs
slv_en  out  NUM_CH  channel enable
slv_prio  out  NUM_CH*2  channel priority, 2 bits per channel
slv_len  out  NUM_CH*3  packet length code, 3 bits per channel

Behaviour:
- Reset: clk and rstn as already decided (rstn asynchronous, active-high). While rstn=1, all three RW regs = RW_RST, cmd_data_r=0, cmd_err=0. Outputs are therefore slv_en=3'b111, slv_prio=6'b111111, slv_len=0.
- Address map:
  - 0x00/0x04/0x08: RW config ch0/ch1/ch2. bit0 en, bits[2:1] prio, bits[5:3] len, bits[31:6] reserved.
  - 0x10/0x14/0x18: RO status ch0/ch1/ch2. bits[AVAIL_W-1:0] = slv_avail of that channel, rest 0.
- Write: on a clk edge where cmd=WR and addr is an RW reg, bits[5:0] of cmd_data_w are stored. Reserved bits are discarded and read back as 0. Outputs update the same edge, so they are visible in the next cycle.
- Write to an RO address or an unmapped address: no state change; cmd_err=1 for one cycle.
- Read: on the edge where cmd=RD is sampled, cmd_data_r loads the addressed value. Latency is 1 cycle; the value holds until the next RD edge.
  - RO read returns slv_avail as sampled at that edge.
  - Unmapped read: cmd_data_r loads 0 and cmd_err pulses.
- IDLE: no state change; cmd_data_r holds its last value; cmd_err=0.
- cmd=11: no state change, cmd_data_r holds, cmd_err pulses.
- Back-to-back WR then RD of the same addr: RD returns the newly written value (write committed on the prior edge).
- Address decoding uses the full ADDR_W with no aliasing; addr[1:0]≠0 counts as unmapped.
- len field is stored raw (0..7). Downstream interprets 0..3 as 4/8/16/32 words and ≥4 as 32. This block does not clamp.
- Reset asserted mid-stream: all state returns to reset values asynchronously; commands are ignored while rstn=1. The first command honoured is on the first clk edge after rstn falls.
- cmd_err is registered and is never high for two consecutive cycles unless two consecutive erroneous commands occur.

Decomposition:
- Package mcdf_pkg holds:
  - cmd encodings IDLE/RD/WR/ILL;
  - register address constants SLV0_RW..SLV2_RW and SLV0_R..SLV2_R;
  - field LSB/width constants for en/prio/len;
  - RW_RST;
  - a packed struct for the config fields.
  The stimulus stage shares this package.
- Sub-module ctrl_reg_slice: one per channel. It holds one RW config register with a write strobe and exposes its en/prio/len and a read value. The top level does address decode, the read mux, and error generation.

Test Plan:
- Reset, then RD 0x00, 0x04, 0x08 -> cmd_data_r = 0x0000_0007 each, one cycle after each RD; slv_en=3'b111, slv_prio=6'h3F, slv_len=0.
- WR 0x04 data 0xFFFF_FFC9, then RD 0x04 next cycle -> cmd_data_r=0x0000_0009; slv_en[1]=1, prio ch1=2'b00, len ch1=3'b001; ch0/ch2 unchanged.
- slv_avail={8'd5,8'd17,8'd32}, RD 0x10, 0x14, 0x18 -> 0x20, 0x11, 0x05; then WR 0x10 data 0x0 -> cmd_err pulse, subsequent RD 0x10 still 0x20.
- RD 0x0C, RD 0x01, cmd=11 -> cmd_err high on each of the three following cycles; cmd_data_r = 0, 0, then held at 0; no config change.
- WR 0x00 data 0x0, then assert rstn mid-sequence during a WR 0x08 data 0x0 -> all regs read 0x0000_0007 after reset release; the WR to 0x08 is lost.
- WR 0x08 data 0x3E immediately followed by RD 0x08 -> cmd_data_r=0x0000_003E on the cycle after RD; slv_en[2]=0.
